// File: rtl/traffic_phase_scheduler.sv
// Master sequencer: wall-clock time keeping plus the day/night signal
// phase rings with yellow, pedestrian extension and emergency override.
module traffic_phase_scheduler #(
  parameter int TICKS_PER_SEC   = 1000,
  parameter int DAY_PHASE_SEC   = 5,
  parameter int NIGHT_PHASE_SEC = 10,
  parameter int YELLOW_SEC      = 1,
  parameter int PED_EXTRA_SEC   = 3,
  parameter int START_HOUR      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       time_set,
  input  logic [4:0] set_hour,
  input  logic [5:0] set_minute,
  input  logic       ped_req,
  input  logic       emergency,
  output logic [4:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic [3:0] situation,
  output logic [4:0] phase_remain,
  output logic       yellow,
  output logic       sec_pulse
);

  localparam int PW =
    (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);

  localparam logic [4:0] DAY_DUR   = 5'(DAY_PHASE_SEC);
  localparam logic [4:0] NIGHT_DUR = 5'(NIGHT_PHASE_SEC);
  localparam logic [4:0] YEL_DUR   = 5'(YELLOW_SEC);
  localparam logic [4:0] PED_DUR   = 5'(PED_EXTRA_SEC);
  localparam logic [4:0] HOUR_RST  = 5'(START_HOUR);

  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_EMERG = 1'b1;

  localparam logic [3:0] SIT_A  = 4'd1;
  localparam logic [3:0] SIT_F  = 4'd6;
  localparam logic [3:0] SIT_G  = 4'd7;
  localparam logic [3:0] SIT_H  = 4'd8;
  localparam logic [3:0] SIT_EM = 4'd9;

  logic [PW-1:0] pre_q, pre_d;
  logic [4:0]    hour_q, hour_d;
  logic [5:0]    min_q, min_d;
  logic [5:0]    sec_q, sec_d;
  logic [3:0]    sit_q, sit_d;
  logic [4:0]    rem_q, rem_d;
  logic          yel_q, yel_d;
  logic          pulse_q, pulse_d;
  logic          ped_q, ped_d;
  logic [0:0]    state_q, state_d;

  logic       load;
  logic       tick;
  logic       day;
  logic [4:0] base;
  logic [3:0] nxt;

  always_comb begin
    load = time_set && (set_hour <= 5'd23) &&
           (set_minute <= 6'd59);
    tick = (pre_q == PRE_MAX) && !load;

    pre_d  = (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;
    hour_d = hour_q;
    min_d  = min_q;
    sec_d  = sec_q;

    if (load) begin
      pre_d  = '0;
      hour_d = set_hour;
      min_d  = set_minute;
      sec_d  = 6'd0;
    end else if (tick) begin
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d  = 6'd0;
          hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
    end

    // Mode is judged on the hour this edge will hold.
    day  = (hour_d >= 5'd8) && (hour_d < 5'd23);
    base = day ? DAY_DUR : NIGHT_DUR;

    nxt = SIT_A;
    unique case (1'b1)
      !day && (sit_q == SIT_G):                 nxt = SIT_H;
      !day && (sit_q != SIT_G):                 nxt = SIT_G;
      day && (sit_q >= SIT_A) && (sit_q < SIT_F): nxt = sit_q + 4'd1;
      default:                                  nxt = SIT_A;
    endcase

    state_d = state_q;
    sit_d   = sit_q;
    rem_d   = rem_q;
    ped_d   = ped_q;

    unique case (state_q)
      S_RUN: begin
        if (emergency) begin
          state_d = S_EMERG;
          sit_d   = SIT_EM;
          ped_d   = ped_q | ped_req;
        end else if (tick && (rem_q == 5'd1)) begin
          sit_d = nxt;
          rem_d = base + (ped_q ? PED_DUR : 5'd0);
          ped_d = ped_req;
        end else begin
          ped_d = ped_q | ped_req;
          if (tick) rem_d = rem_q - 5'd1;
        end
      end
      default: begin
        if (!emergency) begin
          state_d = S_RUN;
          sit_d   = day ? SIT_A : SIT_G;
          rem_d   = base;
          ped_d   = 1'b0;
        end
      end
    endcase

    yel_d   = (state_d == S_RUN) && (rem_d <= YEL_DUR);
    pulse_d = tick;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pre_q   <= '0;
      hour_q  <= HOUR_RST;
      min_q   <= 6'd0;
      sec_q   <= 6'd0;
      sit_q   <= SIT_A;
      rem_q   <= DAY_DUR;
      yel_q   <= 1'b0;
      pulse_q <= 1'b0;
      ped_q   <= 1'b0;
      state_q <= S_RUN;
    end else begin
      pre_q   <= pre_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
      sit_q   <= sit_d;
      rem_q   <= rem_d;
      yel_q   <= yel_d;
      pulse_q <= pulse_d;
      ped_q   <= ped_d;
      state_q <= state_d;
    end
  end

  assign hour         = hour_q;
  assign minute       = min_q;
  assign second       = sec_q;
  assign situation    = sit_q;
  assign phase_remain = rem_q;
  assign yellow       = yel_q;
  assign sec_pulse    = pulse_q;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Bench for traffic_phase_scheduler: directed plan steps plus random
// traffic, all checked against a time-of-day based reference model.
module tb_traffic_phase_scheduler;

  localparam int T     = 4;
  localparam int DAY   = 5;
  localparam int NIGHT = 10;
  localparam int YEL   = 1;
  localparam int PED   = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       time_set = 1'b0;
  logic [4:0] set_hour = '0;
  logic [5:0] set_minute = '0;
  logic       ped_req = 1'b0;
  logic       emergency = 1'b0;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic [3:0] situation;
  logic [4:0] phase_remain;
  logic       yellow;
  logic       sec_pulse;

  int n_cmp = 0;
  int n_bad = 0;

  traffic_phase_scheduler #(
    .TICKS_PER_SEC(T),
    .DAY_PHASE_SEC(DAY),
    .NIGHT_PHASE_SEC(NIGHT),
    .YELLOW_SEC(YEL),
    .PED_EXTRA_SEC(PED),
    .START_HOUR(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .time_set(time_set),
    .set_hour(set_hour),
    .set_minute(set_minute),
    .ped_req(ped_req),
    .emergency(emergency),
    .hour(hour),
    .minute(minute),
    .second(second),
    .situation(situation),
    .phase_remain(phase_remain),
    .yellow(yellow),
    .sec_pulse(sec_pulse)
  );

  always #5 clk = ~clk;

  // Reference model: time of day in seconds, ring tables
  int m_tod, m_pre, m_pulse, m_em, m_sit, m_rem, m_ped;
  int day_ring[6] = '{1, 2, 3, 4, 5, 6};
  int night_ring[2] = '{7, 8};

  function automatic int ring_next(int s, bit is_day);
    if (is_day) begin
      for (int i = 0; i < 6; i++)
        if (day_ring[i] == s) return day_ring[(i + 1) % 6];
      return day_ring[0];
    end
    for (int i = 0; i < 2; i++)
      if (night_ring[i] == s) return night_ring[(i + 1) % 2];
    return night_ring[0];
  endfunction

  task automatic model_step();
    bit tk, ld, is_day;
    int hr, base, nped;
    if (!rst) begin
      m_tod = 8 * 3600; m_pre = 0; m_pulse = 0;
      m_em = 0; m_sit = 1; m_rem = DAY; m_ped = 0;
      return;
    end
    ld = time_set && (set_hour <= 23) && (set_minute <= 59);
    tk = (m_pre == T - 1) && !ld;
    if (ld) begin
      m_tod = int'(set_hour) * 3600 + int'(set_minute) * 60;
      m_pre = 0;
    end else begin
      m_pre = (m_pre + 1) % T;
      if (tk) m_tod = (m_tod + 1) % 86400;
    end
    m_pulse = tk;
    hr = m_tod / 3600;
    is_day = (hr >= 8) && (hr < 23);
    base = is_day ? DAY : NIGHT;
    if (m_em == 0) begin
      if (emergency) begin
        m_em = 1;
        m_ped = m_ped | int'(ped_req);
      end else begin
        nped = m_ped | int'(ped_req);
        if (tk) begin
          if (m_rem == 1) begin
            m_sit = ring_next(m_sit, is_day);
            m_rem = base + (m_ped != 0 ? PED : 0);
            nped = int'(ped_req);
          end else begin
            m_rem = m_rem - 1;
          end
        end
        m_ped = nped;
      end
    end else if (!emergency) begin
      m_em = 0;
      m_sit = is_day ? 1 : 7;
      m_rem = base;
      m_ped = 0;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("hour", 32'(hour), m_tod / 3600);
    chk("minute", 32'(minute), (m_tod / 60) % 60);
    chk("second", 32'(second), m_tod % 60);
    chk("situation", 32'(situation), m_em != 0 ? 9 : m_sit);
    chk("phase_remain", 32'(phase_remain), m_rem);
    chk("yellow", 32'(yellow),
        (m_em == 0 && m_rem <= YEL) ? 1 : 0);
    chk("sec_pulse", 32'(sec_pulse), m_pulse);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic wait_for(int sit, int rem, int lim, string tag);
    int n = 0;
    while (!((sit < 0 || int'(situation) == sit) &&
             (rem < 0 || int'(phase_remain) == rem)) && n < lim) begin
      cyc();
      n++;
    end
    chk(tag, 32'(n < lim), 1);
  endtask

  task automatic set_time(int h, int m);
    set_hour = 5'(h);
    set_minute = 6'(m);
    time_set = 1'b1;
    cyc();
    time_set = 1'b0;
  endtask

  int seen[$];
  int exp_seq[6] = '{2, 3, 4, 5, 6, 1};
  logic [3:0] last_sit;

  initial begin
    // Reset state
    cyc();
    cyc();
    chk("rst_sit", 32'(situation), 1);
    chk("rst_rem", 32'(phase_remain), 5);
    chk("rst_hour", 32'(hour), 8);
    rst = 1'b1;

    // Prescaler: pulse on every 4th edge
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("pulse_cadence", 32'(sec_pulse), (i == 3) ? 1 : 0);
    end
    chk("first_second", 32'(second), 1);

    // Day ring over 30 s
    last_sit = situation;
    for (int i = 0; i < 30 * T; i++) begin
      cyc();
      if (situation != last_sit) seen.push_back(int'(situation));
      last_sit = situation;
    end
    chk("ring_len", 32'(seen.size()), 6);
    for (int i = 0; i < 6 && i < seen.size(); i++)
      chk("ring_seq", 32'(seen[i]), exp_seq[i]);

    // Pedestrian extension in phase B
    wait_for(2, -1, 40 * T, "wait_B");
    cyc();
    ped_req = 1'b1;
    cyc();
    ped_req = 1'b0;
    wait_for(3, -1, 10 * T, "wait_C");
    chk("ped_C_rem", 32'(phase_remain), 8);
    wait_for(4, -1, 10 * T, "wait_D");
    chk("ped_D_rem", 32'(phase_remain), 5);

    // Emergency override
    wait_for(-1, 3, 10 * T, "wait_rem3");
    emergency = 1'b1;
    cyc();
    chk("em_sit", 32'(situation), 9);
    chk("em_rem", 32'(phase_remain), 3);
    chk("em_yel", 32'(yellow), 0);
    set_time(13, 59);
    for (int i = 0; i < 60 * T; i++) begin
      ped_req = (i == 100);
      cyc();
    end
    ped_req = 1'b0;
    chk("em_hour", 32'(hour), 14);
    chk("em_hold", 32'(phase_remain), 3);
    emergency = 1'b0;
    cyc();
    chk("exit_sit", 32'(situation), 1);
    chk("exit_rem", 32'(phase_remain), 5);
    wait_for(2, -1, 10 * T, "wait_B2");
    chk("no_ped_ext", 32'(phase_remain), 5);

    // Hour rollover into night
    set_time(22, 59);
    for (int i = 0; i < 60 * T; i++) cyc();
    chk("roll_hour", 32'(hour), 23);
    chk("roll_min", 32'(minute), 0);
    chk("roll_sec", 32'(second), 0);
    wait_for(7, -1, 20 * T, "wait_G");
    chk("night_rem", 32'(phase_remain), 10);

    // Invalid time_set, then reset mid-phase D
    set_time(24, 10);
    chk("bad_set_hour", 32'(hour), 23);
    set_time(10, 0);
    wait_for(4, -1, 80 * T, "wait_D2");
    repeat (4) cyc();
    rst = 1'b0;
    cyc();
    chk("rst2_sit", 32'(situation), 1);
    chk("rst2_rem", 32'(phase_remain), 5);
    chk("rst2_hour", 32'(hour), 8);
    chk("rst2_yel", 32'(yellow), 0);
    rst = 1'b1;

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      ped_req = ($urandom % 12) == 0;
      if (($urandom % 60) == 0) emergency = ~emergency;
      if (($urandom % 90) == 0) begin
        set_hour = 5'($urandom % 28);
        set_minute = 6'($urandom % 64);
        time_set = 1'b1;
      end else begin
        time_set = 1'b0;
      end
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
